// File: rtl/sample_histogram.sv
// -----------------------------------------------------------------------------
// sample_histogram
//   Bins the state indices produced by the sampler into saturating counters
//   and exposes the bins, a status word and a control word on a simple
//   SEL/ADDR/WRITE/WDATA/RDATA register bus (this block is the responder).
//
// Ports:
//   CLK_I     - clock
//   RESETN_I  - asynchronous active-low reset
//   DONE_I    - one-cycle pulse, RESULT_I valid in that cycle
//   RESULT_I  - packed indices, index i at [RESULT_WID*i +: RESULT_WID]
//   SEL_I     - bus chip select
//   ADDR_I    - bus byte address (bits [1:0] ignored)
//   WRITE_I   - 1 = write, 0 = read
//   WDATA_I   - bus write data
//   RDATA_O   - registered bus read data (holds until the next read)
//   BUSY_O    - high while bins are being updated
//   OVF_O     - sticky, set when an increment hits a saturated bin
// -----------------------------------------------------------------------------
module sample_histogram #(
  parameter int RESULT_WID  = 5,
  parameter int NUM_RESULTS = 16,
  parameter int NUM_BINS    = 32,
  parameter int CNT_WID     = 16
) (
  input  logic                              CLK_I,
  input  logic                              RESETN_I,
  input  logic                              DONE_I,
  input  logic [RESULT_WID*NUM_RESULTS-1:0] RESULT_I,
  input  logic                              SEL_I,
  input  logic [31:0]                       ADDR_I,
  input  logic                              WRITE_I,
  input  logic [31:0]                       WDATA_I,
  output logic [31:0]                       RDATA_O,
  output logic                              BUSY_O,
  output logic                              OVF_O
);

  localparam int                  IDX_WID  = $clog2(NUM_RESULTS);
  localparam logic [IDX_WID-1:0]  LAST_IDX = IDX_WID'(NUM_RESULTS - 1);
  localparam logic [CNT_WID-1:0]  CNT_MAX  = {CNT_WID{1'b1}};
  localparam logic [5:0]          WORD_STATUS = 6'h20;
  localparam logic [5:0]          WORD_CTRL   = 6'h21;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                              state_q;
  logic [IDX_WID-1:0]                  idx_q;
  logic [RESULT_WID*NUM_RESULTS-1:0]   capture_q;
  // Two-stage update: ACCUM fetches capture[i] into sel_q, the next edge
  // increments BIN[sel_q]. This puts update i at T+2+i and frees the FSM
  // to accept a new DONE_I at T+17 while the last increment completes.
  logic [RESULT_WID-1:0]               sel_q;
  logic                                wb_q;
  logic                                last_q;
  logic [CNT_WID-1:0]                  bins_q [NUM_BINS];
  logic [15:0]                         batch_q;
  logic                                ovf_q;
  logic                                drop_q;
  logic                                freeze_q;
  logic [31:0]                         rdata_q;
  logic [31:0]                         rdata_d;

  logic                                addr_ok_s;
  logic [5:0]                          word_s;
  logic                                rd_s;
  logic                                ctrl_wr_s;
  logic                                clear_s;
  logic                                unused_s;

  assign addr_ok_s = (ADDR_I[31:8] == 24'd0);
  assign word_s    = ADDR_I[7:2];
  assign rd_s      = SEL_I & ~WRITE_I;
  assign ctrl_wr_s = SEL_I & WRITE_I & addr_ok_s & (word_s == WORD_CTRL);
  assign clear_s   = ctrl_wr_s & WDATA_I[0];
  assign unused_s  = ^{WDATA_I[31:2], ADDR_I[1:0]};

  // Read mux: bins, status and control, zero for anything unmapped.
  always_comb begin
    rdata_d = 32'd0;
    if (!addr_ok_s) begin
      rdata_d = 32'd0;
    end else if (!word_s[5]) begin
      rdata_d = 32'(bins_q[word_s[4:0]]);
    end else begin
      case (word_s)
        WORD_STATUS: rdata_d = {batch_q, 12'd0, freeze_q, drop_q, ovf_q, wb_q};
        WORD_CTRL:   rdata_d = {30'd0, freeze_q, 1'b0};
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  // Bus registers, FSM and bin update pipeline.
  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state_q   <= IDLE;
      idx_q     <= {IDX_WID{1'b0}};
      capture_q <= {(RESULT_WID*NUM_RESULTS){1'b0}};
      sel_q     <= {RESULT_WID{1'b0}};
      wb_q      <= 1'b0;
      last_q    <= 1'b0;
      for (int k = 0; k < NUM_BINS; k++) bins_q[k] <= {CNT_WID{1'b0}};
      batch_q   <= 16'd0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      freeze_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      // Reads see register state before this edge's updates.
      if (rd_s) rdata_q <= rdata_d;
      if (ctrl_wr_s) freeze_q <= WDATA_I[1];

      if (clear_s) begin
        // Clear wins over everything, including a same-cycle DONE_I.
        state_q <= IDLE;
        idx_q   <= {IDX_WID{1'b0}};
        wb_q    <= 1'b0;
        last_q  <= 1'b0;
        for (int k = 0; k < NUM_BINS; k++) bins_q[k] <= {CNT_WID{1'b0}};
        batch_q <= 16'd0;
        ovf_q   <= 1'b0;
        drop_q  <= 1'b0;
      end else begin
        if (wb_q) begin
          if (bins_q[sel_q] == CNT_MAX) begin
            ovf_q <= 1'b1;
          end else begin
            bins_q[sel_q] <= bins_q[sel_q] + CNT_WID'(1'b1);
          end
          if (last_q) batch_q <= batch_q + 16'd1;
        end

        wb_q   <= 1'b0;
        last_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (DONE_I && !freeze_q) begin
              capture_q <= RESULT_I;
              idx_q     <= {IDX_WID{1'b0}};
              state_q   <= ACCUM;
            end
          end
          ACCUM: begin
            sel_q  <= capture_q[RESULT_WID*idx_q +: RESULT_WID];
            wb_q   <= 1'b1;
            last_q <= (idx_q == LAST_IDX);
            idx_q  <= idx_q + IDX_WID'(1'b1);
            if (idx_q == LAST_IDX) state_q <= IDLE;
            if (DONE_I) drop_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign RDATA_O = rdata_q;
  assign BUSY_O  = wb_q;
  assign OVF_O   = ovf_q;

endmodule

// File: tb/tb_sample_histogram.sv
module tb_sample_histogram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done;
  logic [79:0] result;
  logic        sel;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata16, rdata4;
  logic        busy16, busy4, ovf16, ovf4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sample_histogram dut (
    .CLK_I(clk), .RESETN_I(rst_n), .DONE_I(done), .RESULT_I(result),
    .SEL_I(sel), .ADDR_I(addr), .WRITE_I(wr), .WDATA_I(wdata),
    .RDATA_O(rdata16), .BUSY_O(busy16), .OVF_O(ovf16)
  );

  // Narrow-counter instance for saturation; shares all inputs.
  sample_histogram #(.CNT_WID(4)) dut4 (
    .CLK_I(clk), .RESETN_I(rst_n), .DONE_I(done), .RESULT_I(result),
    .SEL_I(sel), .ADDR_I(addr), .WRITE_I(wr), .WDATA_I(wdata),
    .RDATA_O(rdata4), .BUSY_O(busy4), .OVF_O(ovf4)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d16, output logic [31:0] d4);
    sel = 1'b1; wr = 1'b0; addr = a;
    tick(1);
    sel = 1'b0; addr = 32'd0;
    d16 = rdata16; d4 = rdata4;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick(1);
    sel = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic pulse(input logic [79:0] v);
    done = 1'b1; result = v;
    tick(1);
    done = 1'b0;
  endtask

  function automatic logic [79:0] all_same(input logic [4:0] v);
    logic [79:0] r;
    for (int i = 0; i < 16; i++) r[5*i +: 5] = v;
    return r;
  endfunction

  function automatic logic [79:0] ramp();
    logic [79:0] r;
    for (int i = 0; i < 16; i++) r[5*i +: 5] = 5'(i);
    return r;
  endfunction

  logic [31:0] d16, d4;
  int          busy_cnt, busy_first;

  initial begin
    rst_n = 1'b0; done = 1'b0; result = 80'd0;
    sel = 1'b0; addr = 32'd0; wr = 1'b0; wdata = 32'd0;
    #12;
    check("rst_rdata", rdata16, 32'd0);
    check("rst_busy", {31'd0, busy16}, 32'd0);
    check("rst_ovf", {31'd0, ovf16}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    bus_rd(32'h80, d16, d4); check("rst_status", d16, 32'd0);
    bus_rd(32'h84, d16, d4); check("rst_ctrl", d16, 32'd0);

    // Uniform batch: indices 0..15, busy must be high exactly 16 cycles
    pulse(ramp());
    busy_cnt = 0; busy_first = -1;
    for (int c = 0; c < 30; c++) begin
      if (busy16) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
      end
      tick(1);
    end
    check("uni_busy_cycles", 32'(busy_cnt), 32'd16);
    check("uni_busy_start", 32'(busy_first), 32'd1);

    for (int k = 0; k < 32; k++)
      tbl.push_back('{1'b0, 32'(4*k), 32'd0, (k < 16) ? 32'd1 : 32'd0});
    tbl.push_back('{1'b0, 32'h104, 32'd0, 32'd0});        // high address bits set
    tbl.push_back('{1'b0, 32'h04,  32'd0, 32'd1});
    tbl.push_back('{1'b0, 32'h88,  32'd0, 32'd0});        // unmapped word
    tbl.push_back('{1'b1, 32'h04,  32'hFFFF, 32'd0});     // write to read-only bin
    tbl.push_back('{1'b1, 32'h80,  32'hFFFF, 32'd0});     // write to STATUS
    tbl.push_back('{1'b0, 32'h04,  32'd0, 32'd1});
    tbl.push_back('{1'b0, 32'h80,  32'd0, 32'h0001_0000});
    tbl.push_back('{1'b0, 32'h84,  32'd0, 32'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) begin
        bus_wr(tbl[i].a, tbl[i].d);
      end else begin
        bus_rd(tbl[i].a, d16, d4);
        check($sformatf("uni_vec%0d_a%0h", i, tbl[i].a), d16, tbl[i].exp);
      end
    end

    // Duplicates: 3 batches of sixteen 31s
    bus_wr(32'h84, 32'd1);
    pulse(all_same(5'd31)); tick(19);
    pulse(all_same(5'd31)); tick(19);
    pulse(all_same(5'd31)); tick(20);
    bus_rd(32'h7C, d16, d4); check("dup_bin31", d16, 32'd48);
    bus_rd(32'h80, d16, d4); check("dup_status", d16, 32'h0003_0000);

    // Overrun: T accepted, T+5 dropped, T+17 accepted
    bus_wr(32'h84, 32'd1);
    pulse(all_same(5'd3));
    tick(4);  pulse(all_same(5'd9));
    tick(11); pulse(all_same(5'd12));
    tick(20);
    bus_rd(32'h0C, d16, d4); check("ovr_bin3", d16, 32'd16);
    bus_rd(32'h24, d16, d4); check("ovr_bin9", d16, 32'd0);
    bus_rd(32'h30, d16, d4); check("ovr_bin12", d16, 32'd16);
    bus_rd(32'h80, d16, d4); check("ovr_status", d16, 32'h0002_0004);

    // Clear at T+8 together with a DONE_I pulse
    pulse(ramp());
    tick(7);
    done = 1'b1; result = all_same(5'd20);
    sel = 1'b1; wr = 1'b1; addr = 32'h84; wdata = 32'd1;
    tick(1);
    done = 1'b0; sel = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    check("clr_busy_t8", {31'd0, busy16}, 32'd0);
    tick(1);
    check("clr_busy_t9", {31'd0, busy16}, 32'd0);
    tick(20);
    for (int k = 0; k < 32; k++) begin
      bus_rd(32'(4*k), d16, d4);
      check($sformatf("clr_bin%0d", k), d16, 32'd0);
    end
    bus_rd(32'h80, d16, d4); check("clr_status", d16, 32'd0);

    // Freeze: DONE_I ignored, drop stays clear
    bus_wr(32'h84, 32'd2);
    pulse(all_same(5'd4));
    check("frz_busy", {31'd0, busy16}, 32'd0);
    tick(20);
    bus_rd(32'h10, d16, d4); check("frz_bin4", d16, 32'd0);
    bus_rd(32'h80, d16, d4); check("frz_status", d16, 32'h0000_0008);
    bus_rd(32'h84, d16, d4); check("frz_ctrl", d16, 32'h0000_0002);

    // Reset mid-ACCUM clears outputs without a clock edge
    bus_wr(32'h84, 32'd0);
    pulse(all_same(5'd6));
    tick(3);
    bus_rd(32'h80, d16, d4); check("rstm_status_busy", d16, 32'h0000_0001);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_rdata", rdata16, 32'd0);
    check("rstm_busy", {31'd0, busy16}, 32'd0);
    check("rstm_ovf", {31'd0, ovf16}, 32'd0);
    #3 rst_n = 1'b1;
    tick(20);
    check("rstm_busy_after", {31'd0, busy16}, 32'd0);
    bus_rd(32'h18, d16, d4); check("rstm_bin6", d16, 32'd0);
    bus_rd(32'h80, d16, d4); check("rstm_status", d16, 32'd0);

    // Saturation on the 4-bit instance
    pulse(all_same(5'd5)); tick(19);
    pulse(all_same(5'd5)); tick(20);
    check("sat_ovf4", {31'd0, ovf4}, 32'd1);
    check("sat_ovf16", {31'd0, ovf16}, 32'd0);
    bus_rd(32'h14, d16, d4);
    check("sat_bin5_cnt4", d4, 32'd15);
    check("sat_bin5_cnt16", d16, 32'd32);
    bus_rd(32'h80, d16, d4); check("sat_status4", d4, 32'h0002_0002);
    bus_wr(32'h84, 32'd1);
    check("sat_clr_ovf4", {31'd0, ovf4}, 32'd0);
    bus_rd(32'h14, d16, d4); check("sat_clr_bin5", d4, 32'd0);
    bus_rd(32'h80, d16, d4); check("sat_clr_status4", d4, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
